// File: rtl/sys_ctrl_pkg.sv
// ============================================================================
//  Module  : sys_ctrl_pkg
//  Brief   : Shared types and default widths for the system-controller TX path.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sys_ctrl_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ALU_WIDTH      = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SENDING = 2'd2
    } sched_state_e;

    typedef enum logic {
        SRC_RF  = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

endpackage

`default_nettype wire

// File: rtl/sys_tx_scheduler_if.sv
// ============================================================================
//  Module  : sys_tx_scheduler_if
//  Brief   : Requester strobes, UART TX handshake and status of the TX scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface sys_tx_scheduler_if
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ALU_WIDTH  = DEF_ALU_WIDTH
);
    logic [DATA_WIDTH-1:0] rd_d;
    logic                  rd_d_vld;
    logic [ALU_WIDTH-1:0]  alu_out;
    logic                  alu_vld;
    logic                  busy;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] tx_in;
    logic                  tx_vld;
    logic                  ovf_err;
    logic                  tmo_err;
    logic                  sched_busy;

    modport master (
        output rd_d, rd_d_vld, alu_out, alu_vld, busy, err_clr,
        input  tx_in, tx_vld, ovf_err, tmo_err, sched_busy
    );

    modport slave (
        input  rd_d, rd_d_vld, alu_out, alu_vld, busy, err_clr,
        output tx_in, tx_vld, ovf_err, tmo_err, sched_busy
    );
endinterface

`default_nettype wire

// File: rtl/resp_hold_slot.sv
// ============================================================================
//  Module  : resp_hold_slot
//  Brief   : One-deep holding slot with pending flag; flags strobes that find it full.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module resp_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             grant,
    output logic [WIDTH-1:0] data,
    output logic             pend,
    output logic             overflow
);
    logic [WIDTH-1:0] r_data;
    logic             r_pend;
    logic             w_accept;

    // A slot being granted this cycle is free for a new load on the same edge.
    assign w_accept = load && (!r_pend || grant);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= din;
            end
            if (w_accept) begin
                r_pend <= 1'b1;
            end else if (grant) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign data     = r_data;
    assign pend     = r_pend;
    assign overflow = load && r_pend && !grant;

endmodule

`default_nettype wire

// File: rtl/sys_tx_scheduler.sv
// ============================================================================
//  Module  : sys_tx_scheduler
//  Brief   : Round-robin scheduler of RF bytes / ALU words onto one UART TX.
//            Optional PRESENT timeout enabled by `SYS_TX_SCHED_TIMEOUT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sys_tx_scheduler
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ALU_WIDTH      = DEF_ALU_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    sys_tx_scheduler_if.slave bus
);
    logic [DATA_WIDTH-1:0] w_rf_data;
    logic                  w_rf_pend;
    logic                  w_rf_ovf;
    logic [ALU_WIDTH-1:0]  w_alu_data;
    logic                  w_alu_pend;
    logic                  w_alu_ovf;

    sched_state_e          r_state;
    sched_state_e          w_state_nxt;
    src_e                  r_last_grant;
    logic [ALU_WIDTH-1:0]  r_shift;
    logic [1:0]            r_byte_cnt;
    logic                  r_tx_vld;
    logic [DATA_WIDTH-1:0] r_tx_in;
    logic                  r_ovf;

    logic                  w_grant_rf;
    logic                  w_grant_alu;
    logic                  w_tie;
    logic                  w_tx_vld_nxt;
    logic [DATA_WIDTH-1:0] w_tx_in_nxt;
    logic                  w_tmo_abort;

    resp_hold_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.rd_d_vld),
        .din      (bus.rd_d),
        .grant    (w_grant_rf),
        .data     (w_rf_data),
        .pend     (w_rf_pend),
        .overflow (w_rf_ovf)
    );

    resp_hold_slot #(.WIDTH(ALU_WIDTH)) u_alu_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.alu_vld),
        .din      (bus.alu_out),
        .grant    (w_grant_alu),
        .data     (w_alu_data),
        .pend     (w_alu_pend),
        .overflow (w_alu_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_rf  = 1'b0;
        w_grant_alu = 1'b0;
        w_tie       = w_rf_pend && w_alu_pend;
        case (r_state)
            IDLE: begin
                if (w_rf_pend && (!w_alu_pend || r_last_grant == SRC_ALU)) begin
                    w_grant_rf  = 1'b1;
                    w_state_nxt = PRESENT;
                end else if (w_alu_pend) begin
                    w_grant_alu = 1'b1;
                    w_state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.busy) begin
                    w_state_nxt = SENDING;
                end else if (w_tmo_abort) begin
                    w_state_nxt = IDLE;
                end
            end
            SENDING: begin
                if (!bus.busy) begin
                    w_state_nxt = (r_byte_cnt == 2'd2) ? PRESENT : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The request goes up one cycle after entering PRESENT from IDLE, but
    // straight away when moving on to the high byte.
    assign w_tx_vld_nxt = (w_state_nxt == PRESENT) && (r_state != IDLE);
    assign w_tx_in_nxt  = (r_state == SENDING) ? r_shift[ALU_WIDTH-1:DATA_WIDTH]
                                               : r_shift[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= SRC_ALU;
            r_shift      <= '0;
            r_byte_cnt   <= 2'd0;
            r_tx_vld     <= 1'b0;
            r_tx_in      <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_rf) begin
                r_shift    <= {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, w_rf_data};
                r_byte_cnt <= 2'd1;
            end else if (w_grant_alu) begin
                r_shift    <= w_alu_data;
                r_byte_cnt <= 2'd2;
            end else if (r_state == SENDING && !bus.busy) begin
                r_shift    <= r_shift >> DATA_WIDTH;
                r_byte_cnt <= r_byte_cnt - 2'd1;
            end
            // Round-robin pointer only moves when both sources contended.
            if (w_tie && w_grant_rf) begin
                r_last_grant <= SRC_RF;
            end else if (w_tie && w_grant_alu) begin
                r_last_grant <= SRC_ALU;
            end
            r_tx_vld <= w_tx_vld_nxt;
            if (w_tx_vld_nxt) begin
                r_tx_in <= w_tx_in_nxt;
            end
            if (w_rf_ovf || w_alu_ovf) begin
                r_ovf <= 1'b1;
            end else if (bus.err_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef SYS_TX_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo;

    assign w_tmo_abort = (r_state == PRESENT) && !bus.busy &&
                         (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else begin
            if (r_state != PRESENT || w_state_nxt != PRESENT) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_abort) begin
                r_tmo <= 1'b1;
            end else if (bus.err_clr) begin
                r_tmo <= 1'b0;
            end
        end
    end

    assign bus.tmo_err = r_tmo;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_tmo_abort  = 1'b0;
    assign bus.tmo_err  = 1'b0;
`endif

    assign bus.tx_vld     = r_tx_vld;
    assign bus.tx_in      = r_tx_in;
    assign bus.ovf_err    = r_ovf;
    assign bus.sched_busy = (r_state != IDLE) || w_rf_pend || w_alu_pend;

endmodule

`default_nettype wire

// File: doc/sys_tx_scheduler.md
# sys_tx_scheduler

Schedules response traffic from the system controller onto the single UART transmitter. It captures register-file read data (8-bit) and ALU results (16-bit) from two independent requesters and arbitrates between them round-robin. ALU results are serialized as two bytes, low byte first. Each byte is handed to UART TX with a VLD/BUSY handshake, with sticky error reporting.

## Interface
- DATA_WIDTH, 8, UART frame width; RF data width.
- ALU_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH.
- TIMEOUT_CYCLES, 255, max cycles TX_VLD may wait for BUSY (used only with timeout feature).
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-low.
- Rd_D  in  DATA_WIDTH  register-file read data.
- Rd_D_VLD  in  1  single-cycle strobe; Rd_D valid.
- ALU_OUT  in  ALU_WIDTH  ALU result.
- ALU_VLD  in  1  single-cycle strobe; ALU_OUT valid.
- BUSY  in  1  UART TX busy; rises on byte acceptance, falls at frame end.
- ERR_CLR  in  1  clears sticky error flags.
- TX_IN  out  DATA_WIDTH  byte to UART TX (registered).
- TX_VLD  out  1  byte request to UART TX (registered).
- OVF_ERR  out  1  sticky; a request was dropped because its holding slot was full.
- TMO_ERR  out  1  sticky; a frame was aborted by timeout.
- SCHED_BUSY  out  1  high when state != IDLE or any slot is pending.

## Operation
- **Capture slots:**
  - One holding slot per source: rf_hold/rf_pend and alu_hold/alu_pend.
  - A strobe loads its slot and sets pend.
  - Simultaneous Rd_D_VLD and ALU_VLD both capture.
- **Overflow:**
  - A strobe arriving while its slot is pending, and not granted that same cycle, is dropped. The held data is kept and OVF_ERR sets.
  - A strobe arriving in the cycle its slot is granted is captured normally; no error.
- **Arbitration (IDLE only):**
  - One slot pending: grant it.
  - Both pending: grant the source opposite last_grant.
  - last_grant resets to ALU, so RF wins the first tie.
  - Grant clears the pend bit, loads the 16-bit shift register (RF: {8'h00, rf_hold}), and sets byte_cnt = 1 for RF or 2 for ALU.
- **FSM states:**
  - IDLE -> PRESENT on grant.
  - PRESENT: TX_VLD=1, TX_IN=shift[7:0]. On BUSY=1 -> SENDING, with TX_VLD=0 from the next cycle.
  - SENDING: wait for BUSY=0, then decrement byte_cnt and shift right by 8.
    - byte_cnt was 2 -> PRESENT.
    - byte_cnt was 1 -> IDLE.
  - Unused encodings -> IDLE.
- **ERR_CLR:** clears both sticky flags. If an error event occurs in the same cycle, the error wins and the flag stays set.
- **Reset:** applies mid-operation. The frame in flight and all pending slots are discarded.
  - TX_VLD=0, TX_IN=0, OVF_ERR=0, TMO_ERR=0, SCHED_BUSY=0.
  - State = IDLE, last_grant = ALU.

## Timing
- Strobe sampled at edge k -> pend set after k -> grant at edge k+1 -> TX_VLD=1 after edge k+2 (latency 2, with IDLE and no contention).
- TX_VLD drops the cycle after BUSY is first sampled high. TX_IN holds until the next PRESENT.
- ALU high byte: TX_VLD reasserts the cycle after BUSY is sampled low.
- Back-to-back frames: one IDLE cycle between BUSY falling and the next grant.
- BUSY high while in IDLE is ignored.

## Configuration
- Macro: `SYS_TX_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in PRESENT and resets on entry.
  - If it reaches TIMEOUT_CYCLES with BUSY still 0, the whole frame is aborted (including an untransmitted ALU high byte), TMO_ERR sets, and the FSM returns to IDLE.
- **Undefined:**
  - PRESENT waits indefinitely.
  - TMO_ERR is tied to 0 and no counter is synthesized.

## Structure
- Package `sys_ctrl_pkg`:
  - State encoding constants: IDLE, PRESENT, SENDING.
  - Source IDs: SRC_RF, SRC_ALU.
  - Default widths.
- Sub-module `resp_hold_slot`:
  - Parameterized width.
  - Holds data plus pend.
  - Inputs: load, grant.
  - Output: overflow pulse.
  - Instantiated once per source.

## Test plan
- RF single: Rd_D=8'hA5 strobe; BUSY rises 3 cycles after TX_VLD and is held 10 cycles -> TX_IN=A5, TX_VLD high exactly 3 cycles, one frame, SCHED_BUSY then 0.
- ALU two-byte: ALU_OUT=16'h1234 -> TX_IN=34 then 12, with TX_VLD reasserted the cycle after BUSY falls.
- Tie: Rd_D=8'h11 and ALU_OUT=16'hBEEF in the same cycle -> byte order 11, EF, BE. Repeating the tie then sends the ALU result first (round-robin).
- Overflow: two Rd_D_VLD strobes (8'h01, 8'h02) while BUSY is held high -> 8'h01 is transmitted, 8'h02 is dropped, and OVF_ERR=1 until ERR_CLR.
- Reset mid-frame: RST low during SENDING of the ALU low byte -> all outputs 0 the next cycle and no high byte is sent afterward.
- Timeout (macro defined, TIMEOUT_CYCLES=8): BUSY held 0 -> TX_VLD drops after 8 cycles, TMO_ERR=1, and the pending RF request is then served.
